fp_norm_lzc_stage: RTL and testbench
====================================

Name: fp_norm_lzc_stage

Overview:
Pipelined normalisation-control stage of the FP multiplier. It sits between the mantissa multiplier output and the downstream variable left-shift stage. It counts leading zeros of the raw product mantissa, computes the left-shift amount clamped against exponent underflow, and adjusts the exponent. It forwards the unshifted mantissa, shift amount, exponent and flags over a valid/ready handshake.

Parameters:
DW, 16, FP format width (16/32/64); selects derived widths
MANT_MUL, 22, product mantissa width (22/48/106 for DW 16/32/64)
(derived) SHIFT = 5/6/7 for DW 16/32/64; EXP_W = 5/8/11; EW = EXP_W+2 (signed exponent width)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept input
in_sign  in  1  product sign
in_exp  in  EW  signed biased product exponent (two's complement)
in_mant  in  MANT_MUL  raw product mantissa
clr  in  1  synchronous flush; drops all in-flight beats
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_sign  out  1  forwarded sign
out_exp  out  EW  adjusted exponent
out_mant  out  MANT_MUL  unshifted mantissa, forwarded to the shifter
shift_time  out  SHIFT  left-shift amount for the downstream shifter
out_zero  out  1  mantissa was all-zero
out_uflow  out  1  normalisation limited by the exponent; result is subnormal

Behaviour:
- Reset: async on rst=1. Every register clears: s1_valid=0, s2_valid=0, and all output data/flags=0. in_ready=1 once reset is released.
- Two register stages. S1 captures the input beat. S2 captures the result computed combinationally from S1. Latency is 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Handshake: a transfer occurs when valid&ready are both 1 on a clock edge.
  - S2 loads when (!s2_valid || out_ready).
  - S1 advances into S2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Combinational paths: out_ready feeds in_ready; there is no combinational path from in_valid to out_valid.
- Output data stays stable while out_valid=1 and out_ready=0.
- Up to 2 beats are held under backpressure. Order is preserved; no drops or duplicates.
- clr=1: both valids clear on the next edge. Any input presented in the same cycle is discarded. clr has priority over all transfers.
- LZC: lzc = number of zeros above the most significant 1 in the S1 mantissa, counted from bit MANT_MUL-1. Range is 0..MANT_MUL-1.
- Target: the leading 1 lands at bit MANT_MUL-1.
- Shift/exponent rules, with e = S1 exponent signed:
  - Mantissa == 0: shift_time=0, out_exp=0, out_zero=1, out_uflow=0.
  - e <= 1: shift_time=0, out_exp=e.
  - Otherwise: shift_time = min(lzc, e-1), out_exp = e - shift_time.
  - out_uflow = (mantissa != 0) && (lzc > shift_time).
- Width rules:
  - The exponent subtraction is done in EW bits, sign-extended; no overflow is possible since shift_time <= e-1.
  - shift_time never exceeds MANT_MUL-1.
  - out_mant and out_sign are forwarded unchanged.
- The downstream shifter passes its input through unchanged for shift_time=0.

Test Plan (DW=16, MANT_MUL=22):
1. in_mant=22'h200000, in_exp=15, out_ready=1 -> 2 cycles later: out_valid=1, shift_time=0, out_exp=15, out_zero=0, out_uflow=0.
2. in_mant=22'h000400, in_exp=20 -> shift_time=11, out_exp=9, out_uflow=0. Then in_mant=22'h000001, in_exp=5 -> lzc=21, shift_time=4, out_exp=1, out_uflow=1.
3. in_mant=0, in_exp=12 -> out_zero=1, shift_time=0, out_exp=0. Then in_mant=22'h100000, in_exp=-3 -> shift_time=0, out_exp=-3, out_uflow=1.
4. Stream 4 beats back-to-back, with out_ready=0 for cycles 2..5:
   - in_ready falls after 2 beats are held.
   - out_mant stays stable while stalled.
   - After release, all 4 beats emerge in order, with no gaps once out_ready=1.
5. With 2 beats in flight, pulse clr for 1 cycle while in_valid=1 -> out_valid=0 next cycle, no stale beat ever appears, and the next fresh beat has latency 2.
6. Assert rst asynchronously mid-stream (between clock edges) -> out_valid, shift_time, out_exp and flags go 0 immediately. After release, in_ready=1 and a new beat completes correctly.

Source files
------------

// File: rtl/fp_norm_lzc_stage_if.sv
// fp_norm_lzc_stage_if: valid/ready bus of the normalisation-control stage.
// Upstream side: in_valid/in_ready, in_sign, in_exp (signed EW), in_mant, clr.
// Downstream side: out_valid/out_ready, out_sign, out_exp, out_mant,
// shift_time, out_zero, out_uflow.
// The master drives inputs and out_ready; the slave (the stage) drives the rest.
interface fp_norm_lzc_stage_if #(
  parameter int DW       = 16,
  parameter int MANT_MUL = 22
);
  localparam int SHIFT = DW == 64 ? 7 : DW == 32 ? 6 : 5;
  localparam int EXP_W = DW == 64 ? 11 : DW == 32 ? 8 : 5;
  localparam int EW    = EXP_W + 2;
  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic [EW-1:0]       in_exp;
  logic [MANT_MUL-1:0] in_mant;
  logic                clr;
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [EW-1:0]       out_exp;
  logic [MANT_MUL-1:0] out_mant;
  logic [SHIFT-1:0]    shift_time;
  logic                out_zero;
  logic                out_uflow;
  modport master (
    output in_valid, in_sign, in_exp, in_mant, clr, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, shift_time, out_zero, out_uflow
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, clr, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, shift_time, out_zero, out_uflow
  );
endinterface

// File: rtl/fp_norm_lzc_stage.sv
// fp_norm_lzc_stage: two-stage leading-zero count and exponent-clamped shift control.
// Ports: clk, rst (async active-high), bus (fp_norm_lzc_stage_if.slave).
// S1 registers the input beat; S2 registers shift_time, the adjusted exponent and
// flags computed from S1, with the mantissa and sign forwarded unshifted.
module fp_norm_lzc_stage #(
  parameter int DW       = 16,
  parameter int MANT_MUL = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_norm_lzc_stage_if.slave   bus
);
  localparam int SHIFT = DW == 64 ? 7 : DW == 32 ? 6 : 5;
  localparam int EXP_W = DW == 64 ? 11 : DW == 32 ? 8 : 5;
  localparam int EW    = EXP_W + 2;
  localparam int CW    = (SHIFT > EW ? SHIFT : EW) + 1;
  logic                s1_valid;
  logic                s1_sign;
  logic [EW-1:0]       s1_exp;
  logic [MANT_MUL-1:0] s1_mant;
  logic                adv;
  logic                nz;
  logic                e_gt1;
  logic                found;
  logic [SHIFT-1:0]    lzc;
  logic [SHIFT-1:0]    sh;
  logic [CW-1:0]       lzc_x;
  logic [CW-1:0]       lim_x;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv;
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = MANT_MUL - 1; i >= 0; i--) begin
      if (!found && s1_mant[i]) found = 1'b1;
      else if (!found) lzc = lzc + SHIFT'(1);
    end
  end
  assign nz    = |s1_mant;
  assign e_gt1 = $signed(s1_exp) > $signed(EW'(1));
  // e-1 is only consulted when e > 1, so zero-extending it is safe.
  assign lzc_x = CW'(lzc);
  assign lim_x = CW'(s1_exp - EW'(1));
  assign sh    = (nz && e_gt1) ? (lzc_x < lim_x ? lzc : lim_x[SHIFT-1:0]) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
    end else if (bus.clr) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.in_sign;
        s1_exp  <= bus.in_exp;
        s1_mant <= bus.in_mant;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_sign   <= 1'b0;
      bus.out_exp    <= '0;
      bus.out_mant   <= '0;
      bus.shift_time <= '0;
      bus.out_zero   <= 1'b0;
      bus.out_uflow  <= 1'b0;
    end else if (bus.clr) begin
      bus.out_valid <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sign   <= s1_sign;
        bus.out_exp    <= nz ? s1_exp - EW'(sh) : '0;
        bus.out_mant   <= s1_mant;
        bus.shift_time <= sh;
        bus.out_zero   <= !nz;
        bus.out_uflow  <= nz && (lzc > sh);
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_lzc_stage.sv
// tb_fp_norm_lzc_stage: directed and randomized checks against a reference model.
module tb_fp_norm_lzc_stage;
  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic [21:0] mant;
    logic [4:0]  sh;
    logic        zero;
    logic        uflow;
  } beat_t;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  fp_norm_lzc_stage_if #(.DW(16), .MANT_MUL(22)) bus();
  fp_norm_lzc_stage #(.DW(16), .MANT_MUL(22)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic beat_t model(input logic s, input logic [6:0] ex, input logic [21:0] m);
    beat_t r;
    int e  = int'($signed(ex));
    int mv = int'(m);
    int lz = 0;
    int sh;
    if (mv != 0) while (mv < (1 << 21)) begin mv = mv * 2; lz++; end
    sh = (m == 0 || e <= 1) ? 0 : (lz < e - 1 ? lz : e - 1);
    r.sign  = s;
    r.mant  = m;
    r.sh    = 5'(sh);
    r.exp   = (m == 0) ? 7'd0 : 7'(e - sh);
    r.zero  = (m == 0);
    r.uflow = (m != 0) && (lz > sh);
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [21:0] m, input logic [6:0] e);
    bus.in_valid = 1'b1;
    bus.in_sign  = m[0];
    bus.in_mant  = m;
    bus.in_exp   = e;
    tick();
    bus.in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rst || bus.clr) exp_q.delete();
    else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
        else begin
          chk("sb_sign", 64'(bus.out_sign), 64'(exp_q[0].sign));
          chk("sb_exp", 64'(bus.out_exp), 64'(exp_q[0].exp));
          chk("sb_mant", 64'(bus.out_mant), 64'(exp_q[0].mant));
          chk("sb_shift", 64'(bus.shift_time), 64'(exp_q[0].sh));
          chk("sb_zero", 64'(bus.out_zero), 64'(exp_q[0].zero));
          chk("sb_uflow", 64'(bus.out_uflow), 64'(exp_q[0].uflow));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_sign, bus.in_exp, bus.in_mant));
    end
  end
  initial begin
    beat_t bt[4];
    int idx;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_shift", 64'(bus.shift_time), 64'd0);
    chk("rst_exp", 64'(bus.out_exp), 64'd0);
    chk("rst_flags", 64'({bus.out_zero, bus.out_uflow}), 64'd0);
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    send(22'h200000, 7'd15);
    chk("t1_lat1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t1_lat2_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_shift", 64'(bus.shift_time), 64'd0);
    chk("t1_exp", 64'(bus.out_exp), 64'd15);
    chk("t1_flags", 64'({bus.out_zero, bus.out_uflow}), 64'd0);
    send(22'h000400, 7'd20);
    send(22'h000001, 7'd5);
    chk("t2a_shift", 64'(bus.shift_time), 64'd11);
    chk("t2a_exp", 64'(bus.out_exp), 64'd9);
    chk("t2a_uflow", 64'(bus.out_uflow), 64'd0);
    tick();
    chk("t2b_shift", 64'(bus.shift_time), 64'd4);
    chk("t2b_exp", 64'(bus.out_exp), 64'd1);
    chk("t2b_uflow", 64'(bus.out_uflow), 64'd1);
    send(22'h000000, 7'd12);
    send(22'h100000, -7'sd3);
    chk("t3a_zero", 64'(bus.out_zero), 64'd1);
    chk("t3a_shift", 64'(bus.shift_time), 64'd0);
    chk("t3a_exp", 64'(bus.out_exp), 64'd0);
    tick();
    chk("t3b_shift", 64'(bus.shift_time), 64'd0);
    chk("t3b_exp", 64'(bus.out_exp), 64'h7d);
    chk("t3b_uflow", 64'(bus.out_uflow), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) bt[i] = model(1'b0, 7'(10 + i), 22'h200000 >> (3 * i + 1));
    idx = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc <= 5);
      bus.in_valid  = idx < 4;
      if (idx < 4) begin
        bus.in_sign = bt[idx].sign;
        bus.in_exp  = bt[idx].exp;
        bus.in_mant = bt[idx].mant;
      end
      #3;
      if (cyc <= 6) chk("t4_in_ready", 64'(bus.in_ready), 64'(!(cyc >= 3 && cyc <= 5)));
      if (cyc >= 3 && cyc <= 5) chk("t4_stall_mant", 64'(bus.out_mant), 64'(bt[0].mant));
      if (cyc >= 6 && cyc <= 9) chk("t4_no_gap", 64'(bus.out_valid), 64'd1);
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    send(22'h0f0000, 7'd30);
    send(22'h00f000, 7'd30);
    chk("t5_inflight", 64'(bus.out_valid), 64'd1);
    bus.clr      = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_mant  = 22'h3abcde;
    bus.in_exp   = 7'd9;
    tick();
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("t5_clr_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_clr_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_stale", 64'(bus.out_valid), 64'd0);
    end
    send(22'h000400, 7'd20);
    chk("t5_fresh_lat1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t5_fresh_lat2", 64'(bus.out_valid), 64'd1);
    chk("t5_fresh_shift", 64'(bus.shift_time), 64'd11);
    send(22'h000400, 7'd20);
    send(22'h000400, 7'd20);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_shift", 64'(bus.shift_time), 64'd0);
    chk("t6_exp", 64'(bus.out_exp), 64'd0);
    chk("t6_flags", 64'({bus.out_zero, bus.out_uflow}), 64'd0);
    tick();
    rst = 1'b0;
    chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
    send(22'h000001, 7'd5);
    chk("t6_lat1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("t6_lat2", 64'(bus.out_valid), 64'd1);
    chk("t6_shift_new", 64'(bus.shift_time), 64'd4);
    chk("t6_exp_new", 64'(bus.out_exp), 64'd1);
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.in_sign   = 1'($urandom);
      bus.in_exp    = 7'($urandom);
      bus.in_mant   = 22'($urandom) >> $urandom_range(0, 22);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
